// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (ABCDEFG, MSB=A)
// used by both the hex decoder and the capture path, plus the capture FSM states.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_encoder.sv
// Inverse of the hex-to-segment decoder: maps an active-low ABCDEFG pattern back
// to its nibble, flagging a dark digit as blank and anything else as invalid.
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    nibble  = '0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Observes a multiplexed active-low seven-segment bus, filters each digit for
// stability, reassembles the displayed word and hands it off with valid/ready.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            SEG,
  input  logic [DIGITS-1:0]     AN,
  input  logic                  RDY,
  output logic [4*DIGITS-1:0]   WORD,
  output logic [DIGITS-1:0]     BLANK,
  output logic                  ERR,
  output logic                  VLD,
  output logic                  OVR
);

  localparam int unsigned CW = $clog2(STABLE + 1);

  logic [DIGITS+6:0]   bus;
  logic [DIGITS+6:0]   sample;
  logic [CW-1:0]       cnt;
  logic                fresh;
  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   an_s;
  logic                capture;

  logic [3:0]          nibble;
  logic                blank;
  logic                invalid;

  logic [4*DIGITS-1:0] asm_word, word_n;
  logic [DIGITS-1:0]   asm_blank, blank_n;
  logic [DIGITS-1:0]   seen, seen_n;
  logic                pend_err, err_n;
  logic                complete;

  state_t              state, state_n;
  logic                load;
  logic                drop;

  assign bus   = {AN, SEG};
  assign seg_s = sample[6:0];
  assign an_s  = sample[DIGITS+6:7];

  // fresh marks the single cycle after the counter first saturates, so a long
  // stable window yields exactly one capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample <= '1;
      cnt    <= '0;
      fresh  <= 1'b0;
    end else begin
      sample <= bus;
      if (bus != sample) begin
        cnt   <= CW'(1);
        fresh <= 1'b0;
      end else begin
        if (cnt != CW'(STABLE)) cnt <= cnt + CW'(1);
        fresh <= (cnt == CW'(STABLE - 1));
      end
    end
  end

  assign capture = fresh && $onehot(~an_s);

  seven_seg_encoder u_encoder (
    .pattern (seg_s),
    .nibble  (nibble),
    .blank   (blank),
    .invalid (invalid)
  );

  always_comb begin
    word_n  = asm_word;
    blank_n = asm_blank;
    seen_n  = seen;
    err_n   = pend_err;
    if (capture) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (!an_s[i]) begin
          word_n[4*i +: 4] = nibble;
          blank_n[i]       = blank;
          seen_n[i]        = 1'b1;
        end
      end
      err_n = pend_err | invalid;
    end
  end

  assign complete = capture && (&seen_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_word  <= '0;
      asm_blank <= '0;
      seen      <= '0;
      pend_err  <= 1'b0;
    end else begin
      asm_word  <= word_n;
      asm_blank <= blank_n;
      seen      <= complete ? '0 : seen_n;
      pend_err  <= complete ? 1'b0 : err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // In FULL, VLD is always high, so the handshake reduces to RDY.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    drop    = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_n = FULL;
        end
      end
      FULL: begin
        if (RDY) begin
          if (complete) load    = 1'b1;
          else          state_n = EMPTY;
        end else if (complete) begin
          drop = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  assign VLD = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WORD  <= '0;
      BLANK <= '0;
      ERR   <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      OVR <= drop;
      if (load) begin
        WORD  <= word_n;
        BLANK <= blank_n;
        ERR   <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scans plus random display traffic,
// checked against a dwell-based frame model and a handshake monitor.
module tb_seven_seg_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  SEG = 7'h7F;
  logic [3:0]  AN  = 4'hF;
  logic        RDY = 1'b1;
  logic [15:0] WORD;
  logic [3:0]  BLANK;
  logic        ERR;
  logic        VLD;
  logic        OVR;

  always #5 clk = ~clk;

  seven_seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .SEG   (SEG),
    .AN    (AN),
    .RDY   (RDY),
    .WORD  (WORD),
    .BLANK (BLANK),
    .ERR   (ERR),
    .VLD   (VLD),
    .OVR   (OVR)
  );

  logic [6:0] pat_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  blank;
    logic        err;
  } frame_t;

  frame_t expq [$];
  int vectors     = 0;
  int miscompares = 0;
  int exp_drops   = 0;
  int ovr_cycles  = 0;

  // Model: a displayed value captures once its uninterrupted dwell reaches STABLE.
  logic [10:0] m_prev;
  int          m_run;
  bit          m_capped;
  logic [15:0] m_word;
  logic [3:0]  m_blank;
  logic [3:0]  m_seen;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_prev   = '1;
    m_run    = 0;
    m_capped = 1'b1;
    m_word   = '0;
    m_blank  = '0;
    m_seen   = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] an, input logic [6:0] seg, input int n);
    logic [10:0] v;
    int d;
    logic [3:0] nib;
    bit blk, bad;
    v = {an, seg};
    if (v == m_prev) m_run += n;
    else begin
      m_run    = n;
      m_capped = 1'b0;
    end
    m_prev = v;
    if (!m_capped && m_run >= STABLE) begin
      m_capped = 1'b1;
      if ($countones(~an) == 1) begin
        d = 0;
        for (int i = 0; i < DIGITS; i++) if (!an[i]) d = i;
        nib = 4'h0; blk = 1'b0; bad = 1'b1;
        if (seg == 7'h7F) begin
          blk = 1'b1; bad = 1'b0;
        end else begin
          for (int k = 0; k < 16; k++) if (pat_tab[k] == seg) begin
            nib = 4'(k); bad = 1'b0;
          end
        end
        m_word[4*d +: 4] = nib;
        m_blank[d]       = blk;
        m_seen[d]        = 1'b1;
        m_err            = m_err | bad;
        if (m_seen == 4'hF) begin
          if (expq.size() != 0) exp_drops++;
          else expq.push_back({m_word, m_blank, m_err});
          m_seen = '0;
          m_err  = 1'b0;
        end
      end
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN  = an;
    SEG = seg;
    model_step(an, seg, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sel(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic scan(input logic [15:0] nibs, input int dwell);
    for (int i = 0; i < DIGITS; i++) show(sel(i), pat_tab[nibs[4*i +: 4]], dwell);
  endtask

  // Handshake monitor: every accepted frame must match the model, and a stalled
  // frame must not move.
  frame_t held;
  bit     hold_prev = 1'b0;
  frame_t front;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (OVR) ovr_cycles++;
      if (hold_prev) check("stall_hold", {VLD, WORD, BLANK, ERR}, {1'b1, held});
      if (VLD && RDY) begin
        vectors++;
        assert (expq.size() > 0) else begin
          miscompares++;
          $error("FAIL spurious_vld: observed frame %0h expected none", {WORD, BLANK, ERR});
        end
        if (expq.size() > 0) begin
          front = expq.pop_front();
          check("frame", {WORD, BLANK, ERR}, front);
        end
      end
      hold_prev = VLD && !RDY;
      held      = {WORD, BLANK, ERR};
    end
  end

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    int a, b, dw;

    model_reset();
    #2 rst = 1'b1;
    #2;
    check("rst_word",  WORD,  0);
    check("rst_blank", BLANK, 0);
    check("rst_err",   ERR,   0);
    check("rst_vld",   VLD,   0);
    check("rst_ovr",   OVR,   0);
    @(posedge clk); #1;
    rst = 1'b0;

    scan(16'h4321, 8);
    show(4'hF, 7'h7F, 6);
    check("word_4321", WORD, 16'h4321);
    check("vld_4321_drop", VLD, 0);
    check("q_4321", expq.size(), 0);

    show(sel(0), pat_tab[15], 8);
    show(sel(1), pat_tab[15], 8);
    show(sel(2), 7'h7F, 8);
    show(sel(3), pat_tab[15], 8);
    show(4'hF, 7'h7F, 6);
    check("word_f0ff", WORD, 16'hF0FF);
    check("blank_f0ff", BLANK, 4'b0100);

    show(sel(0), pat_tab[8], 3);
    show(sel(0), pat_tab[0], 8);
    show(sel(1), pat_tab[1], 8);
    show(sel(2), pat_tab[2], 8);
    show(sel(3), pat_tab[3], 8);
    show(4'hF, 7'h7F, 6);
    check("glitch_word", WORD, 16'h3210);

    show(sel(0), pat_tab[5], 8);
    show(sel(1), 7'b1111110, 8);
    show(sel(2), pat_tab[5], 8);
    show(sel(3), pat_tab[5], 8);
    show(4'hF, 7'h7F, 6);
    check("err_set", ERR, 1);
    check("err_word", WORD, 16'h5505);
    scan(16'h9876, 8);
    show(4'hF, 7'h7F, 6);
    check("err_clear", ERR, 0);

    RDY = 1'b0;
    scan(16'hDCBA, 8);
    scan(16'h1111, 8);
    show(4'hF, 7'h7F, 6);
    check("ovr_vld_held", VLD, 1);
    check("ovr_word_held", WORD, 16'hDCBA);
    check("ovr_pulses", ovr_cycles, exp_drops);
    check("ovr_expected", exp_drops, 1);
    RDY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_vld_drop", VLD, 0);

    show(sel(0), pat_tab[5], 8);
    show(sel(1), pat_tab[6], 8);
    #3 rst = 1'b1;
    #1;
    check("arst_word", WORD, 0);
    check("arst_vld",  VLD,  0);
    AN = 4'hF; SEG = 7'h7F;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    show(sel(2), pat_tab[0], 8);
    show(sel(3), pat_tab[12], 8);
    show(4'hF, 7'h7F, 6);
    check("arst_partial_vld", VLD, 0);
    check("arst_partial_q", expq.size(), 0);
    show(sel(0), pat_tab[7], 8);
    show(sel(1), pat_tab[3], 8);
    show(4'hF, 7'h7F, 6);
    check("arst_word_new", WORD, 16'hC037);

    for (int s = 0; s < 400; s++) begin
      do begin
        a = $urandom_range(0, 99);
        if (a < 80) an = sel($urandom_range(0, 3));
        else if (a < 90) an = 4'hF;
        else begin
          a = $urandom_range(0, 3);
          do b = $urandom_range(0, 3); while (b == a);
          an = sel(a) & sel(b);
        end
        a = $urandom_range(0, 99);
        if (a < 85) seg = pat_tab[$urandom_range(0, 15)];
        else if (a < 93) seg = 7'h7F;
        else seg = 7'($urandom);
      end while ({an, seg} == m_prev);
      dw = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 9);
      show(an, seg, dw);
    end
    show(4'hF, 7'h7F, 10);
    check("rand_q_empty", expq.size(), 0);
    check("rand_ovr", ovr_cycles, exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
